// File: rtl/cordic_bus_master.sv
// rtl/cordic_bus_master.sv - bus master sequencing one CORDIC job: write operands, start, poll done, read results
module cordic_bus_master #(
    parameter logic [5:0] ADDR_X    = 6'h00,
    parameter logic [5:0] ADDR_Y    = 6'h04,
    parameter logic [5:0] ADDR_Z    = 6'h08,
    parameter logic [5:0] ADDR_CTRL = 6'h0C,
    parameter logic [5:0] ADDR_STAT = 6'h10,
    parameter logic [5:0] ADDR_XOUT = 6'h14,
    parameter logic [5:0] ADDR_YOUT = 6'h18,
    parameter int         TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    input  logic [31:0] job_x,
    input  logic [31:0] job_y,
    input  logic [31:0] job_z,
    output logic        job_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_x,
    output logic [31:0] res_y,
    output logic        res_err,
    output logic [31:0] bus_data_out,
    output logic [5:0]  bus_addr,
    output logic        bus_wr,
    input  logic [31:0] bus_data_in
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_X,
        S_WR_Y,
        S_WR_Z,
        S_WR_GO,
        S_POLL_A,
        S_POLL_D,
        S_RD_XA,
        S_RD_XD,
        S_RD_YA,
        S_RD_YD,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [31:0]        r_x;
    logic [31:0]        r_y;
    logic [31:0]        r_z;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_res_x;
    logic [31:0]        r_res_y;
    logic               r_err;

    logic               w_done;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_poll_last;

    // Only bit 0 of the status word carries meaning; the rest is ignored.
    assign w_done      = bus_data_in[0];
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    // The poll just sampled is the last one allowed if it brings the count to TIMEOUT.
    assign w_poll_last = (w_cnt_inc >= CNT_W'(TIMEOUT));

    assign res_x   = r_res_x;
    assign res_y   = r_res_y;
    assign res_err = r_err;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand latch, poll counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= 32'h0;
            r_y     <= 32'h0;
            r_z     <= 32'h0;
            r_cnt   <= '0;
            r_res_x <= 32'h0;
            r_res_y <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (job_valid) begin
                        r_x   <= job_x;
                        r_y   <= job_y;
                        r_z   <= job_z;
                        r_cnt <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_POLL_D: begin
                    if (!w_done) begin
                        if (w_poll_last) begin
                            r_res_x <= 32'h0;
                            r_res_y <= 32'h0;
                            r_err   <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_RD_XD: r_res_x <= bus_data_in;
                S_RD_YD: r_res_y <= bus_data_in;
                default: ;
            endcase
        end
    end

    // Next state and bus/handshake outputs; the address is driven only in
    // the cycle a write or read request is issued and is zero otherwise.
    always_comb begin
        w_next       = r_state;
        bus_wr       = 1'b0;
        bus_addr     = 6'h00;
        bus_data_out = 32'h0;
        job_ready    = 1'b0;
        res_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) w_next = S_WR_X;
            end
            S_WR_X: begin
                bus_wr       = 1'b1;
                bus_addr     = ADDR_X;
                bus_data_out = r_x;
                w_next       = S_WR_Y;
            end
            S_WR_Y: begin
                bus_wr       = 1'b1;
                bus_addr     = ADDR_Y;
                bus_data_out = r_y;
                w_next       = S_WR_Z;
            end
            S_WR_Z: begin
                bus_wr       = 1'b1;
                bus_addr     = ADDR_Z;
                bus_data_out = r_z;
                w_next       = S_WR_GO;
            end
            S_WR_GO: begin
                bus_wr       = 1'b1;
                bus_addr     = ADDR_CTRL;
                bus_data_out = 32'h1;
                w_next       = S_POLL_A;
            end
            S_POLL_A: begin
                bus_addr = ADDR_STAT;
                w_next   = S_POLL_D;
            end
            S_POLL_D: begin
                if (w_done) begin
                    w_next = S_RD_XA;
                end else if (w_poll_last) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_POLL_A;
                end
            end
            S_RD_XA: begin
                bus_addr = ADDR_XOUT;
                w_next   = S_RD_XD;
            end
            S_RD_XD: w_next = S_RD_YA;
            S_RD_YA: begin
                bus_addr = ADDR_YOUT;
                w_next   = S_RD_YD;
            end
            S_RD_YD: w_next = S_RESP;
            S_RESP: begin
                res_valid = 1'b1;
                if (res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cordic_bus_master.sv
// tb/tb_cordic_bus_master.sv - self-checking bench for cordic_bus_master with a peripheral model
module tb_cordic_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic [31:0] job_x = 32'h0;
    logic [31:0] job_y = 32'h0;
    logic [31:0] job_z = 32'h0;
    logic        job_ready;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_x;
    logic [31:0] res_y;
    logic        res_err;
    logic [31:0] bus_data_out;
    logic [5:0]  bus_addr;
    logic        bus_wr;
    logic [31:0] bus_data_in = 32'h0;

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;

    // peripheral model state
    int          p_polls = 3;   // done reported on this status read; 0 = never
    int          p_seen  = 0;
    logic [31:0] px = 32'h0;
    logic [31:0] py = 32'h0;
    logic [31:0] pz = 32'h0;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;
    wr_t wq[$];
    int  stat_total = 0;

    cordic_bus_master dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_x        (job_x),
        .job_y        (job_y),
        .job_z        (job_z),
        .job_ready    (job_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_x        (res_x),
        .res_y        (res_y),
        .res_err      (res_err),
        .bus_data_out (bus_data_out),
        .bus_addr     (bus_addr),
        .bus_wr       (bus_wr),
        .bus_data_in  (bus_data_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic f_done(input int seen, input int polls);
        return (polls != 0) && (seen + 1 >= polls);
    endfunction

    // Peripheral: registered writes, 1-cycle read latency, random status upper bits.
    always @(posedge clk) begin
        if (bus_wr) begin
            case (bus_addr)
                6'h00: px <= bus_data_out;
                6'h04: py <= bus_data_out;
                6'h08: pz <= bus_data_out;
                6'h0C: if (bus_data_out[0]) p_seen <= 0;
                default: ;
            endcase
            bus_data_in <= $urandom;
        end else begin
            case (bus_addr)
                6'h10: begin
                    bus_data_in <= {31'($urandom), f_done(p_seen, p_polls)};
                    p_seen      <= p_seen + 1;
                end
                6'h14:   bus_data_in <= px + pz;
                6'h18:   bus_data_in <= py - pz;
                default: bus_data_in <= $urandom;
            endcase
        end
    end

    // Bus monitor
    always @(negedge clk) begin
        if (bus_wr === 1'b1) wq.push_back('{a: bus_addr, d: bus_data_out, c: cyc});
        if (bus_wr === 1'b0 && bus_addr === 6'h10) stat_total <= stat_total + 1;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nchecks++;
        if (res_valid !== 1'b0 || res_err !== 1'b0) begin
            nerr++; $display("FAIL reset_res_flags: res_valid=%b res_err=%b required 0 0", res_valid, res_err);
        end
        nchecks++;
        if (res_x !== 32'h0 || res_y !== 32'h0) begin
            nerr++; $display("FAIL reset_res_data: res_x=%h res_y=%h required 0 0", res_x, res_y);
        end
        nchecks++;
        if (bus_wr !== 1'b0 || bus_addr !== 6'h0 || bus_data_out !== 32'h0) begin
            nerr++; $display("FAIL reset_bus: wr=%b addr=%h data=%h required 0 0 0", bus_wr, bus_addr, bus_data_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // res_ready with no result pending must do nothing
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        nchecks++;
        if (job_ready !== 1'b1 || res_valid !== 1'b0 || bus_wr !== 1'b0) begin
            nerr++; $display("FAIL idle_after_reset: job_ready=%b res_valid=%b bus_wr=%b required 1 0 0", job_ready, res_valid, bus_wr);
        end
    endtask

    task automatic run_job(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                           input int polls, input int hold, input bit pulse);
        int c0, rc, wbase, sbase, erc, ereads;
        bit got, eerr;
        logic [31:0] ex, ey;
        logic [5:0]  ea [4];
        logic [31:0] ed [4];
        @(posedge clk); #1;
        p_polls = polls;
        wbase = wq.size();
        sbase = stat_total;
        job_x = x; job_y = y; job_z = z; job_valid = 1'b1;
        @(negedge clk);
        c0 = cyc;
        nchecks++;
        if (job_ready !== 1'b1) begin
            nerr++; $display("FAIL job_ready_idle: got %b required 1", job_ready);
        end
        @(posedge clk); #1;
        job_valid = 1'b0;
        got = 1'b0;
        rc = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                got = 1'b1;
                rc = cyc;
            end else if (pulse) begin
                if (cyc == c0 + 7) begin
                    job_valid = 1'b1;
                    job_x = $urandom; job_y = $urandom; job_z = $urandom;
                end
                if (cyc >= c0 + 7 && cyc <= c0 + 9) begin
                    nchecks++;
                    if (job_ready !== 1'b0) begin
                        nerr++; $display("FAIL job_ready_busy: got %b required 0 at cycle %0d", job_ready, cyc - c0);
                    end
                end
                if (cyc == c0 + 10) job_valid = 1'b0;
            end
        end
        nchecks++;
        if (!got) begin
            nerr++; $display("FAIL res_valid_timeout: no res_valid within 400 cycles required one");
            return;
        end
        eerr   = (polls < 1 || polls > 64);
        ex     = eerr ? 32'h0 : x + z;
        ey     = eerr ? 32'h0 : y - z;
        erc    = eerr ? c0 + 133 : c0 + 9 + 2 * polls;
        ereads = eerr ? 64 : polls;
        ea = '{6'h00, 6'h04, 6'h08, 6'h0C};
        ed = '{x, y, z, 32'h1};
        nchecks++;
        if (rc != erc) begin
            nerr++; $display("FAIL latency: res_valid at %0d required %0d", rc - c0, erc - c0);
        end
        nchecks++;
        if (stat_total - sbase != ereads) begin
            nerr++; $display("FAIL status_reads: got %0d required %0d", stat_total - sbase, ereads);
        end
        nchecks++;
        if (res_err !== eerr || res_x !== ex || res_y !== ey) begin
            nerr++; $display("FAIL result: err=%b x=%h y=%h required %b %h %h", res_err, res_x, res_y, eerr, ex, ey);
        end
        nchecks++;
        if (wq.size() - wbase != 4) begin
            nerr++; $display("FAIL write_count: got %0d required 4", wq.size() - wbase);
        end else begin
            for (int k = 0; k < 4; k++) begin
                nchecks++;
                if (wq[wbase+k].a !== ea[k] || wq[wbase+k].d !== ed[k] || wq[wbase+k].c != c0 + 1 + k) begin
                    nerr++; $display("FAIL write_%0d: addr=%h data=%h cyc=%0d required %h %h %0d", k,
                        wq[wbase+k].a, wq[wbase+k].d, wq[wbase+k].c - c0, ea[k], ed[k], 1 + k);
                end
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            nchecks++;
            if (res_valid !== 1'b1 || res_x !== ex || res_y !== ey || res_err !== eerr ||
                job_ready !== 1'b0 || bus_wr !== 1'b0 || bus_addr !== 6'h0) begin
                nerr++; $display("FAIL resp_hold: valid=%b x=%h y=%h err=%b ready=%b wr=%b addr=%h required 1 %h %h %b 0 0 00",
                    res_valid, res_x, res_y, res_err, job_ready, bus_wr, bus_addr, ex, ey, eerr);
            end
        end
        if (hold > 0) begin
            nchecks++;
            if (wq.size() - wbase != 4 || stat_total - sbase != ereads) begin
                nerr++; $display("FAIL resp_bus_quiet: writes=%0d reads=%0d required 4 %0d",
                    wq.size() - wbase, stat_total - sbase, ereads);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        nchecks++;
        if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
            nerr++; $display("FAIL handshake: res_valid=%b job_ready=%b required 0 1", res_valid, job_ready);
        end
    endtask

    task automatic test_reset_mid_job();
        int wbase, sbase;
        @(posedge clk); #1;
        p_polls = 3;
        wbase = wq.size();
        sbase = stat_total;
        job_x = 32'h1111_1111; job_y = 32'h2222_2222; job_z = 32'h3333_3333; job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        nchecks++;
        if (bus_wr !== 1'b1 || bus_addr !== 6'h04) begin
            nerr++; $display("FAIL in_wr_y: wr=%b addr=%h required 1 04", bus_wr, bus_addr);
        end
        @(negedge clk);
        nchecks++;
        if (bus_wr !== 1'b0 || job_ready !== 1'b1 || res_valid !== 1'b0 || bus_addr !== 6'h0) begin
            nerr++; $display("FAIL reset_abort: wr=%b ready=%b valid=%b addr=%h required 0 1 0 00",
                bus_wr, job_ready, res_valid, bus_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        nchecks++;
        if (wq.size() - wbase != 2 || stat_total - sbase != 0 || res_valid !== 1'b0) begin
            nerr++; $display("FAIL abandoned: writes=%0d reads=%0d valid=%b required 2 0 0",
                wq.size() - wbase, stat_total - sbase, res_valid);
        end
        run_job($urandom, $urandom, $urandom, 2, 0, 1'b0);
    endtask

    task automatic test_back_to_back(input int polls);
        logic [31:0] ax, ay, az, bx, by, bz;
        int c0, c1, r1, r2, wbase;
        bit got;
        ax = $urandom; ay = $urandom; az = $urandom;
        bx = $urandom; by = $urandom; bz = $urandom;
        @(posedge clk); #1;
        p_polls = polls;
        wbase = wq.size();
        res_ready = 1'b1;
        job_x = ax; job_y = ay; job_z = az; job_valid = 1'b1;
        @(negedge clk);
        c0 = cyc;
        @(posedge clk); #1;
        job_x = bx; job_y = by; job_z = bz;
        got = 1'b0; r1 = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin got = 1'b1; r1 = cyc; end
        end
        nchecks++;
        if (!got || r1 != c0 + 9 + 2 * polls || res_x !== ax + az || res_y !== ay - az) begin
            nerr++; $display("FAIL b2b_first: at=%0d x=%h y=%h required %0d %h %h",
                r1 - c0, res_x, res_y, 9 + 2 * polls, ax + az, ay - az);
        end
        @(negedge clk);
        c1 = cyc;
        nchecks++;
        if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
            nerr++; $display("FAIL b2b_idle: res_valid=%b job_ready=%b required 0 1", res_valid, job_ready);
        end
        @(posedge clk); #1;
        job_valid = 1'b0;
        got = 1'b0; r2 = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin got = 1'b1; r2 = cyc; end
        end
        nchecks++;
        if (!got || r2 != c1 + 9 + 2 * polls || res_x !== bx + bz || res_y !== by - bz) begin
            nerr++; $display("FAIL b2b_second: at=%0d x=%h y=%h required %0d %h %h",
                r2 - c1, res_x, res_y, 9 + 2 * polls, bx + bz, by - bz);
        end
        nchecks++;
        if (wq.size() - wbase != 8) begin
            nerr++; $display("FAIL b2b_writes: got %0d required 8", wq.size() - wbase);
        end else begin
            nchecks++;
            if (wq[wbase+3].c != c0 + 4 || wq[wbase+4].c != c1 + 1 || wq[wbase+4].d !== bx ||
                wq[wbase+0].d !== ax || wq[wbase+6].d !== bz) begin
                nerr++; $display("FAIL b2b_order: a_go=%0d b_x=%0d bx=%h ax=%h bz=%h required %0d %0d %h %h %h",
                    wq[wbase+3].c - c0, wq[wbase+4].c - c0, wq[wbase+4].d, wq[wbase+0].d, wq[wbase+6].d,
                    4, c1 + 1 - c0, bx, ax, bz);
            end
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        nchecks++;
        if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
            nerr++; $display("FAIL b2b_end: job_ready=%b res_valid=%b required 1 0", job_ready, res_valid);
        end
    endtask

    initial begin
        test_reset();
        run_job(32'h0000_4DBA, 32'h0, 32'h0000_2000, 3, 0, 1'b0);
        run_job($urandom, $urandom, $urandom, 0, 2, 1'b0);
        run_job($urandom, $urandom, $urandom, 64, 0, 1'b0);
        run_job($urandom, $urandom, $urandom, 1, 10, 1'b0);
        run_job($urandom, $urandom, $urandom, 5, 0, 1'b1);
        test_reset_mid_job();
        test_back_to_back(2);
        for (int j = 0; j < 5; j++) begin
            run_job($urandom, $urandom, $urandom, $urandom_range(1, 8), $urandom_range(0, 3), 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete required completion");
        $fatal(1);
    end

endmodule

// File: doc/cordic_bus_master.md
CORDIC_BUS_MASTER -- requirements
Module: cordic_bus_master

Interface
REQ-001 Parameter ADDR_X, 6'h00: X operand register address.
REQ-002 Parameter ADDR_Y, 6'h04: Y operand register address.
REQ-003 Parameter ADDR_Z, 6'h08: Z (angle) operand register address.
REQ-004 Parameter ADDR_CTRL, 6'h0C: control register address; bit0 = start.
REQ-005 Parameter ADDR_STAT, 6'h10: status register address; bit0 = done.
REQ-006 Parameter ADDR_XOUT, 6'h14 / ADDR_YOUT, 6'h18: result register addresses.
REQ-007 Parameter TIMEOUT, 64: maximum status polls before abort.
REQ-008 clk  in  1  single clock; all logic on posedge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 job_valid  in  1  job request; job_x/job_y/job_z are valid while high.
REQ-011 job_x, job_y, job_z  in  32 each  signed operands.
REQ-012 job_ready  out  1  high only in IDLE; job accepted on job_valid & job_ready.
REQ-013 res_valid  out  1  result available.
REQ-014 res_ready  in  1  consumer accepts result on res_valid & res_ready.
REQ-015 res_x, res_y  out  32 each  results read from the peripheral.
REQ-016 res_err  out  1  high with res_valid when the job timed out.
REQ-017 bus_data_out  out  32  write data, wired to peripheral write-data input.
REQ-018 bus_addr  out  6  bus address.
REQ-019 bus_wr  out  1  write strobe, one cycle per write.
REQ-020 bus_data_in  in  32  read data from peripheral; valid the cycle after bus_addr is driven (1-cycle read latency).

Function
REQ-021 States SHALL be IDLE, WR_X, WR_Y, WR_Z, WR_GO, POLL_A, POLL_D, RD_XA, RD_XD, RD_YA, RD_YD, RESP; one state per cycle except IDLE/RESP/POLL loop.
REQ-022 On job accept, operands SHALL be latched internally; IDLE -> WR_X next cycle.
REQ-023 WR_X/WR_Y/WR_Z SHALL drive bus_wr=1, bus_addr=ADDR_X/Y/Z, bus_data_out=latched operand.
REQ-024 WR_GO SHALL write 32'h1 to ADDR_CTRL with bus_wr=1.
REQ-025 POLL_A SHALL drive bus_addr=ADDR_STAT, bus_wr=0; POLL_D SHALL sample bus_data_in[0].
REQ-026 In POLL_D: done=1 -> RD_XA; done=0 and poll count < TIMEOUT -> POLL_A with count+1; count reaching TIMEOUT -> RESP with res_err=1, res_x=res_y=0.
REQ-027 Poll counter SHALL be cleared on job accept and sized ceil(log2(TIMEOUT+1)) bits; no wrap.
REQ-028 RD_XA/RD_YA SHALL drive ADDR_XOUT/ADDR_YOUT, bus_wr=0; RD_XD/RD_YD SHALL capture bus_data_in into res_x/res_y.
REQ-029 RESP SHALL hold res_valid=1 and res_x/res_y/res_err stable until res_ready; on handshake -> IDLE, res_valid=0 next cycle.
REQ-030 bus_wr SHALL be 0 in every state other than WR_X, WR_Y, WR_Z, WR_GO.
REQ-031 Successful-job latency, accept to res_valid, SHALL be 4 writes + 2N poll cycles (N = polls until done=1) + 4 read cycles + 1 = 9 + 2N cycles.
REQ-032 job_valid while busy SHALL be ignored (job_ready=0); no queueing.
REQ-033 res_ready while res_valid=0 SHALL have no effect.
REQ-034 If res_valid and job_valid coincide with res_ready, the new job SHALL be accepted no earlier than the cycle after return to IDLE.
REQ-035 Only the peripheral's done bit SHALL be interpreted; other status bits ignored.

Reset
REQ-036 rst=1 at any posedge SHALL force IDLE, job_ready=1 after release, res_valid=0, res_err=0, res_x=res_y=0, bus_wr=0, bus_addr=0, bus_data_out=0, poll count=0.
REQ-037 Reset mid-job SHALL abandon the transaction with no further bus writes; any partially written peripheral registers are not restored.

Verification
REQ-038 Job x=32'h0000_4DBA, y=0, z=32'h0000_2000, peripheral model done after 3 polls -> writes at 00/04/08/0C in 4 consecutive cycles, res_valid at cycle 15, res_x/res_y equal model values, res_err=0.
REQ-039 Model never asserts done -> exactly 64 status reads, then res_valid=1, res_err=1, res_x=res_y=0.
REQ-040 res_ready held low 10 cycles in RESP -> outputs stable, no bus activity, job_ready=0 throughout.
REQ-041 job_valid pulsed during POLL loop -> ignored; only first job's writes appear on bus.
REQ-042 rst asserted in WR_Y -> next cycle bus_wr=0, state IDLE; fresh job afterwards completes normally.
REQ-043 Back-to-back jobs with res_ready=1 -> second job accepted cycle after RESP handshake, no overlap of bus transactions.
